// File: rtl/ntt_input_loader_if.sv
// Streaming coefficient input and frame output bundle for the NTT input loader.
// The master modport is the side that feeds coefficients in and takes frames out.
`timescale 1ns/1ps
interface ntt_input_loader_if #(
    parameter int W = 32,
    parameter int N = 8
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         in_last;
    logic         in_mode;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data [0:N-1];
    logic         out_mode;

    modport master (
        output in_valid, in_data, in_last, in_mode, out_ready,
        input  in_ready, out_valid, out_data, out_mode
    );

    modport slave (
        input  in_valid, in_data, in_last, in_mode, out_ready,
        output in_ready, out_valid, out_data, out_mode
    );
endinterface

// File: rtl/ntt_input_loader.sv
// Ping-pong frame loader: gathers N reduced coefficients per bank and presents
// a complete, zero-padded frame to the NTT core while the other bank fills.
`timescale 1ns/1ps
module ntt_input_loader #(
    parameter int          W         = 32,
    parameter int          N         = 8,
    parameter int unsigned Modulus_Q = 12289999
) (
    input  logic                clk,
    input  logic                reset,
    ntt_input_loader_if.slave   bus,
    output logic                len_err,
    output logic                range_err,
    output logic [15:0]         frame_cnt
);
    localparam int IW = $clog2(N);
    localparam int CW = $clog2(N + 1);

    localparam logic [1:0] ST_EMPTY   = 2'd0;
    localparam logic [1:0] ST_FILLING = 2'd1;
    localparam logic [1:0] ST_FULL    = 2'd2;

    localparam logic [W-1:0] Q1 = W'(Modulus_Q);
    localparam logic [W-1:0] Q2 = W'(2 * Modulus_Q);

    logic [W-1:0]  mem   [0:1][0:N-1];
    logic [1:0]    state [0:1];
    logic [CW-1:0] fill  [0:1];
    logic          mode  [0:1];

    logic          wr_bank;
    logic          rd_bank;
    logic [IW-1:0] wr_idx;

    logic          in_ready_i;
    logic          out_valid_i;
    logic          accept;
    logic          consume;
    logic          at_end;
    logic          close;
    logic [W-1:0]  reduced;

    assign in_ready_i  = (state[wr_bank] != ST_FULL);
    assign out_valid_i = (state[rd_bank] == ST_FULL);
    assign accept      = bus.in_valid && in_ready_i;
    assign consume     = out_valid_i && bus.out_ready;
    assign at_end      = (wr_idx == IW'(N - 1));
    assign close       = bus.in_last || at_end;
    assign reduced     = (bus.in_data >= Q1) ? (bus.in_data - Q1) : bus.in_data;

    assign bus.in_ready  = in_ready_i;
    assign bus.out_valid = out_valid_i;
    assign bus.out_mode  = mode[rd_bank];

    // NOTE: coefficient storage has no reset; stale words are hidden by the fill-count mask.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_bank][wr_idx] <= reduced;
        end
    end

    // NOTE: all registered state uses non-blocking assignment so every update sees pre-edge values.
    // A close and a consume never target the same bank, so both updates can coexist in one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int b = 0; b < 2; b++) begin
                state[b] <= ST_EMPTY;
                fill[b]  <= '0;
                mode[b]  <= 1'b0;
            end
            wr_bank   <= 1'b0;
            rd_bank   <= 1'b0;
            wr_idx    <= '0;
            len_err   <= 1'b0;
            range_err <= 1'b0;
            frame_cnt <= '0;
        end else begin
            len_err   <= accept && close && (bus.in_last != at_end);
            range_err <= accept && (bus.in_data >= Q2);

            if (consume) begin
                state[rd_bank] <= ST_EMPTY;
                fill[rd_bank]  <= '0;
                rd_bank        <= ~rd_bank;
                frame_cnt      <= frame_cnt + 16'd1;
            end

            if (accept) begin
                if (wr_idx == '0) begin
                    mode[wr_bank]  <= bus.in_mode;
                    state[wr_bank] <= ST_FILLING;
                end
                if (close) begin
                    fill[wr_bank]  <= CW'(wr_idx) + CW'(1);
                    state[wr_bank] <= ST_FULL;
                    wr_bank        <= ~wr_bank;
                    wr_idx         <= '0;
                end else begin
                    wr_idx <= wr_idx + IW'(1);
                end
            end
        end
    end

    // NOTE: every output element is assigned on each pass, so no latch can be inferred.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            bus.out_data[i] = (CW'(i) < fill[rd_bank]) ? mem[rd_bank][i] : '0;
        end
    end
endmodule

// File: tb/tb_ntt_input_loader.sv
// Scoreboard bench for ntt_input_loader: a reference model predicts each frame at
// the closing acceptance; a monitor pops and compares whenever a frame is consumed.
`timescale 1ns/1ps
module tb_ntt_input_loader;
    localparam int W  = 32;
    localparam int N  = 8;
    localparam int Q  = 12289999;
    localparam int FW = N * W + 1;

    typedef struct packed {
        logic                mode;
        logic [N-1:0][W-1:0] d;
    } frame_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        len_err;
    logic        range_err;
    logic [15:0] frame_cnt;

    ntt_input_loader_if #(.W(W), .N(N)) intf ();

    ntt_input_loader #(.W(W), .N(N), .Modulus_Q(Q)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (intf.slave),
        .len_err   (len_err),
        .range_err (range_err),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    int     n_checks = 0;
    int     n_err    = 0;
    int     len_pulses   = 0;
    int     range_pulses = 0;
    frame_t exp_q [$];
    frame_t cur;
    int     cur_idx;

    task automatic check(input string tag, input logic [FW-1:0] got, input logic [FW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] reduce(input logic [W-1:0] d);
        if (longint'(d) >= longint'(Q)) return W'(longint'(d) - longint'(Q));
        return d;
    endfunction

    task automatic model_accept(input logic [W-1:0] d, input logic last, input logic mode);
        if (cur_idx == 0) cur.mode = mode;
        cur.d[cur_idx] = reduce(d);
        if (last || cur_idx == N - 1) begin
            exp_q.push_back(cur);
            cur     = '0;
            cur_idx = 0;
        end else begin
            cur_idx++;
        end
    endtask

    // Drive one coefficient; returns #1 after the edge that accepted it.
    task automatic send(input logic [W-1:0] d, input logic last, input logic mode);
        int waited = 0;
        intf.in_valid = 1'b1;
        intf.in_data  = d;
        intf.in_last  = last;
        intf.in_mode  = mode;
        while (!intf.in_ready && waited < 200) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!intf.in_ready) begin
            check("send_timeout", FW'(0), FW'(1));
            intf.in_valid = 1'b0;
            return;
        end
        model_accept(d, last, mode);
        @(posedge clk); #1;
        intf.in_valid = 1'b0;
    endtask

    task automatic drain();
        int waited = 0;
        while (exp_q.size() != 0 && waited < 100) begin
            @(posedge clk); #1;
            waited++;
        end
        check("drain", FW'(exp_q.size()), FW'(0));
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (len_err)   len_pulses++;
            if (range_err) range_pulses++;
            if (intf.out_valid && intf.out_ready) begin
                frame_t obs;
                obs.mode = intf.out_mode;
                for (int i = 0; i < N; i++) obs.d[i] = intf.out_data[i];
                if (exp_q.size() == 0) begin
                    check("unexpected_frame", FW'(1), FW'(0));
                end else begin
                    check("frame", obs, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lp;
        int rp;
        cur = '0;
        cur_idx = 0;
        reset = 1'b1;
        intf.in_valid  = 1'b0;
        intf.in_data   = '0;
        intf.in_last   = 1'b0;
        intf.in_mode   = 1'b0;
        intf.out_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready",  FW'(intf.in_ready),    FW'(1));
        check("rst_out_valid", FW'(intf.out_valid),   FW'(0));
        check("rst_out_mode",  FW'(intf.out_mode),    FW'(0));
        check("rst_frame_cnt", FW'(frame_cnt),        FW'(0));
        check("rst_len_err",   FW'(len_err),          FW'(0));
        check("rst_range_err", FW'(range_err),        FW'(0));
        check("rst_out_data0", FW'(intf.out_data[0]), FW'(0));
        reset = 1'b0;
        @(posedge clk); #1;

        // Full frame 0..7, one-cycle latency, count after consume
        intf.out_ready = 1'b1;
        lp = len_pulses; rp = range_pulses;
        for (int i = 0; i < N - 1; i++) send(W'(i), 1'b0, 1'b0);
        check("lat_before_close", FW'(intf.out_valid), FW'(0));
        send(W'(N - 1), 1'b1, 1'b0);
        check("lat_after_close", FW'(intf.out_valid), FW'(1));
        @(posedge clk); #1;
        check("frame_cnt_1", FW'(frame_cnt), FW'(1));
        check("full_len_err", FW'(len_pulses - lp), FW'(0));
        check("full_range_err", FW'(range_pulses - rp), FW'(0));

        // Modular reduction and range error
        rp = range_pulses;
        send(W'(12290004), 1'b0, 1'b0);
        check("range_below_2q", FW'(range_err), FW'(0));
        send(W'(24580000), 1'b0, 1'b0);
        check("range_at_2q", FW'(range_err), FW'(1));
        for (int i = 2; i < N; i++) send(W'(Q + i), i == N - 1, 1'b0);
        drain();
        check("range_pulses", FW'(range_pulses - rp), FW'(1));

        // Short frame is zero padded
        lp = len_pulses;
        intf.out_ready = 1'b0;
        send(W'(9), 1'b0, 1'b0);
        send(W'(8), 1'b0, 1'b0);
        send(W'(7), 1'b1, 1'b0);
        check("short_len_err", FW'(len_err), FW'(1));
        check("short_pad3", FW'(intf.out_data[3]), FW'(0));
        check("short_word2", FW'(intf.out_data[2]), FW'(7));
        intf.out_ready = 1'b1;
        drain();
        check("short_len_pulses", FW'(len_pulses - lp), FW'(1));

        // Missing in_last still closes at N words
        lp = len_pulses;
        for (int i = 0; i < N; i++) send(W'(40 + i), 1'b0, 1'b0);
        check("nolast_valid", FW'(intf.out_valid), FW'(1));
        drain();
        check("nolast_len_pulses", FW'(len_pulses - lp), FW'(1));

        // Backpressure: both banks fill, then release
        intf.out_ready = 1'b0;
        for (int i = 0; i < N; i++) send(W'(100 + i), i == N - 1, 1'b0);
        for (int i = 0; i < N; i++) send(W'(200 + i), i == N - 1, 1'b0);
        check("bp_in_ready_low", FW'(intf.in_ready), FW'(0));
        repeat (3) @(posedge clk);
        #1;
        check("bp_hold_d0", FW'(intf.out_data[0]), FW'(100));
        check("bp_hold_d7", FW'(intf.out_data[N-1]), FW'(107));
        check("bp_hold_valid", FW'(intf.out_valid), FW'(1));
        intf.out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_in_ready_back", FW'(intf.in_ready), FW'(1));
        send(W'(300), 1'b1, 1'b0);
        drain();

        // Reset mid-frame with one frame full
        intf.out_ready = 1'b0;
        for (int i = 0; i < N; i++) send(W'(500 + i), i == N - 1, 1'b0);
        for (int i = 0; i < 4; i++) send(W'(600 + i), 1'b0, 1'b0);
        reset = 1'b1;
        #1;
        check("mid_rst_out_valid", FW'(intf.out_valid), FW'(0));
        check("mid_rst_in_ready",  FW'(intf.in_ready),  FW'(1));
        check("mid_rst_frame_cnt", FW'(frame_cnt),      FW'(0));
        exp_q.delete();
        cur = '0;
        cur_idx = 0;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) send(W'(700 + i), i == 3, 1'b0);
        check("post_rst_valid", FW'(intf.out_valid), FW'(1));
        check("post_rst_bank0", FW'(dut.rd_bank), FW'(0));
        intf.out_ready = 1'b1;
        drain();

        // Mode capture at index 0, then frame counter wrap
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        intf.out_ready = 1'b0;
        send(W'(11), 1'b0, 1'b1);
        for (int i = 1; i < N; i++) send(W'(11 + i), i == N - 1, 1'b0);
        check("mode_latched", FW'(intf.out_mode), FW'(1));
        intf.out_ready = 1'b1;
        for (int f = 1; f < 65536; f++) begin
            send(W'($urandom_range(0, 2 * Q + 100)), 1'b1, 1'($urandom_range(0, 1)));
        end
        check("cnt_before_wrap", FW'(frame_cnt), FW'(16'hFFFF));
        @(posedge clk); #1;
        check("cnt_wrapped", FW'(frame_cnt), FW'(0));
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
